gol_gen_buffer: RTL and testbench
=================================

# gol_gen_buffer

Double-buffered generation store for the Game of Life datapath. It holds the current generation, which is read combinationally as a three-row neighbourhood window with toroidal row wrap. It collects the next generation row by row from the cell-update logic and flips banks on a swap handshake once every row has been written. It also tracks the generation count and reports stable and extinct boards to the controller.

## Interface

Parameters:
- WIDTH, 8, cells per row (bits per row word); must be ≥1
- REGBITS, 3, row address bits; ROWS = 2**REGBITS; must be ≥1
- GENBITS, 16, generation counter width

Ports:
- ph2  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- load  in  1  host init: write wd into current bank row wa
- regwrite  in  1  write wd into next bank row wa
- wa  in  REGBITS  write row address
- wd  in  WIDTH  write data
- ra  in  REGBITS  read row address
- rd_up  out  WIDTH  current bank row (ra-1) mod ROWS
- rd  out  WIDTH  current bank row ra
- rd_dn  out  WIDTH  current bank row (ra+1) mod ROWS
- swap_req  in  1  request generation flip
- swap_ack  out  1  one-cycle pulse; swap accepted on previous edge
- ready  out  1  every next-bank row written this generation
- gen  out  GENBITS  generations completed since reset
- stable  out  1  last accepted swap produced a board identical to its predecessor
- empty  out  1  current bank is all zeros

## Operation

- Storage: two banks of ROWS×WIDTH flops. A `cur` select flop marks the current bank; the other bank is next.
- Reads: rd_up, rd and rd_dn are purely combinational from the current bank. Row indices wrap modulo ROWS. At ROWS=2, rd_up equals rd_dn.
- Load (load=1): writes wd into current[wa] at the edge. Clears stable. Does not touch the written mask or the change flag. Load takes priority over regwrite; when both are asserted, regwrite is ignored that cycle.
- Next-gen write (regwrite=1, load=0):
  - Writes wd into next[wa].
  - Sets mask[wa].
  - If wd differs from current[wa], sets the sticky `changed` flag.
  - Rewriting a row is legal. The mask stays set, and `changed` stays set even if the rewrite later matches.
- ready = &mask. It is combinational from the registered mask, so it rises the cycle after the edge that writes the last unwritten row.
- Swap is accepted on an edge where swap_req=1 and ready=1. At that edge:
  - `cur` flips.
  - mask clears to 0.
  - gen increments, wrapping modulo 2**GENBITS.
  - stable is loaded with ~changed, then `changed` clears.
  - swap_ack is 1 for the following cycle only.
- swap_req with ready=0 is ignored: no ack and no state change. swap_req may be held high; the swap occurs at the first edge where ready=1.
- A regwrite on the swap edge lands in the old next bank, which becomes current. Its data is visible after the flip and its mask bit does not carry over. Its difference check is included in the stable value loaded at that edge.
- A load on the swap edge writes the old current bank, which becomes next. That data is overwritten or ignored; stable is taken from the swap rule.
- empty = NOR of all current-bank bits. Combinational; follows `cur` immediately after a flip.
- Reset: both banks 0, cur=0, mask=0, changed=0, gen=0, swap_ack=0, stable=0. Hence ready=0, empty=1 and rd_up/rd/rd_dn all 0. Reset mid-generation discards partial writes and any pending swap_req. Reset overrides load, regwrite and swap in the same cycle.

## Timing

- Read latency: 0 cycles (combinational from ra and state).
- Load visible on rd the cycle after its edge.
- Next-gen write visible on rd only after the accepted swap edge.
- Minimum generation period: ROWS write cycles plus one swap edge. The swap may coincide with the last write only if ready was already 1, so normally ROWS+1 edges.
- swap_ack, gen, stable and the new rd values all appear in the same cycle, directly after the swap edge.

## Test plan

- Reset, then idle: rd=rd_up=rd_dn=0, empty=1, ready=0, gen=0, swap_ack=0, stable=0.
- WIDTH=8, REGBITS=3. Load rows 0..7 with 8'h01..8'h08, then ra=0: rd=8'h01, rd_up=8'h08, rd_dn=8'h02. With ra=7: rd_dn=8'h01.
- regwrite rows 0..6, assert swap_req: no swap_ack, gen stays 0. Write row 7: ready=1 next cycle. Swap occurs on the following edge, then swap_ack=1 for one cycle, gen=1, cur flipped.
- Write the next bank identical to the current bank for all rows, then swap: stable=1. Repeat with row 3 differing: stable=0.
- Assert load and regwrite together to row 2 with different data: only the current bank changes and mask[2] stays 0. Then assert reset mid-generation with 5 rows written: ready=0, gen=0, all banks 0.
- Set GENBITS=2 and perform 5 swaps: gen sequence 1,2,3,0,1. Load an all-zero board, then swap: empty=1.

Source files
------------

// File: rtl/gol_gen_buffer_if.sv
// Bundle of the generation-buffer signals shared between the cell-update
// datapath (master) and the double-buffered generation store (slave).
interface gol_gen_buffer_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
);
  logic               load;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic [REGBITS-1:0] ra;
  logic [WIDTH-1:0]   rd_up;
  logic [WIDTH-1:0]   rd;
  logic [WIDTH-1:0]   rd_dn;
  logic               swap_req;
  logic               swap_ack;
  logic               ready;
  logic [GENBITS-1:0] gen;
  logic               stable;
  logic               empty;

  modport master (
    output load, regwrite, wa, wd, ra, swap_req,
    input  rd_up, rd, rd_dn, swap_ack, ready, gen, stable, empty
  );

  modport slave (
    input  load, regwrite, wa, wd, ra, swap_req,
    output rd_up, rd, rd_dn, swap_ack, ready, gen, stable, empty
  );
endinterface

// File: rtl/gol_gen_buffer.sv
// Double-buffered Game of Life generation store: toroidal three-row read
// window on the current bank, row-wise fill of the next bank, swap handshake.
module gol_gen_buffer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic              ph2,
  input  logic              reset,
  gol_gen_buffer_if.slave   bus
);
  localparam int ROWS = 1 << REGBITS;

  logic [1:0][ROWS-1:0][WIDTH-1:0] bank_q, bank_d;
  logic                            cur_q, cur_d;
  logic [ROWS-1:0]                 mask_q, mask_d;
  logic                            changed_q, changed_d;
  logic [GENBITS-1:0]              gen_q, gen_d;
  logic                            stable_q, stable_d;
  logic                            ack_q, ack_d;
  logic                            ready_s;
  logic                            swap_s;
  logic                            diff_s;
  logic [REGBITS-1:0]              ra_up_s;
  logic [REGBITS-1:0]              ra_dn_s;

  assign ready_s = &mask_q;
  assign swap_s  = bus.swap_req & ready_s;
  assign diff_s  = (bus.wd != bank_q[cur_q][bus.wa]);
  // Row arithmetic in REGBITS width gives the toroidal wrap for free.
  assign ra_up_s = bus.ra - REGBITS'(1);
  assign ra_dn_s = bus.ra + REGBITS'(1);

  assign bus.rd_up    = bank_q[cur_q][ra_up_s];
  assign bus.rd       = bank_q[cur_q][bus.ra];
  assign bus.rd_dn    = bank_q[cur_q][ra_dn_s];
  assign bus.ready    = ready_s;
  assign bus.empty    = ~|bank_q[cur_q];
  assign bus.swap_ack = ack_q;
  assign bus.gen      = gen_q;
  assign bus.stable   = stable_q;

  // Next-state: host load, next-bank write with change tracking, bank flip.
  always_comb begin
    bank_d    = bank_q;
    cur_d     = cur_q;
    mask_d    = mask_q;
    changed_d = changed_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    ack_d     = 1'b0;

    if (bus.load) begin
      bank_d[cur_q][bus.wa] = bus.wd;
      stable_d              = 1'b0;
    end else if (bus.regwrite) begin
      bank_d[~cur_q][bus.wa] = bus.wd;
      mask_d[bus.wa]         = 1'b1;
      changed_d              = changed_q | diff_s;
    end else begin
      changed_d = changed_q;
    end

    // The same-edge write's difference is already folded into changed_d.
    if (swap_s) begin
      cur_d     = ~cur_q;
      mask_d    = {ROWS{1'b0}};
      gen_d     = gen_q + GENBITS'(1);
      stable_d  = ~changed_d;
      changed_d = 1'b0;
      ack_d     = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ph2) begin
    if (reset) begin
      bank_q    <= '0;
      cur_q     <= 1'b0;
      mask_q    <= {ROWS{1'b0}};
      changed_q <= 1'b0;
      gen_q     <= {GENBITS{1'b0}};
      stable_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      cur_q     <= cur_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      ack_q     <= ack_d;
    end
  end
endmodule

// File: tb/tb_gol_gen_buffer.sv
// Directed bench for gol_gen_buffer: a reference model pushes expected
// outputs to a scoreboard queue each cycle; they are popped and compared.
module tb_gol_gen_buffer;
  localparam int W = 8;
  localparam int R = 3;
  localparam int G = 2;

  typedef struct packed {
    logic [W-1:0] up;
    logic [W-1:0] mid;
    logic [W-1:0] dn;
    logic         rdy;
    logic         ack;
    logic         stb;
    logic         emp;
    logic [G-1:0] gen;
  } exp_t;

  logic ph2;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  logic [W-1:0] m_bank [0:1][0:7];
  logic         m_cur;
  logic [7:0]   m_mask;
  logic         m_changed;
  logic [G-1:0] m_gen;
  logic         m_stable;
  logic         m_ack;

  gol_gen_buffer_if #(.WIDTH(W), .REGBITS(R), .GENBITS(G)) bus_if ();

  gol_gen_buffer #(.WIDTH(W), .REGBITS(R), .GENBITS(G)) dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 ph2 = ~ph2;

  task automatic model_edge();
    logic swap;
    logic chg;
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++) m_bank[b][r] = 8'h00;
      m_cur = 1'b0; m_mask = 8'h00; m_changed = 1'b0;
      m_gen = '0; m_stable = 1'b0; m_ack = 1'b0;
    end else begin
      swap = bus_if.swap_req && (&m_mask);
      chg  = m_changed;
      if (bus_if.load) begin
        m_bank[m_cur][bus_if.wa] = bus_if.wd;
        m_stable = 1'b0;
      end else if (bus_if.regwrite) begin
        if (bus_if.wd != m_bank[m_cur][bus_if.wa]) chg = 1'b1;
        m_bank[!m_cur][bus_if.wa] = bus_if.wd;
        m_mask[bus_if.wa] = 1'b1;
      end
      m_ack = swap;
      if (swap) begin
        m_cur = !m_cur; m_mask = 8'h00; m_gen = m_gen + 2'd1;
        m_stable = !chg; m_changed = 1'b0;
      end else begin
        m_changed = chg;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [R-1:0] r_up;
    logic [R-1:0] r_dn;
    logic any;
    r_up = bus_if.ra - 3'd1;
    r_dn = bus_if.ra + 3'd1;
    any = 1'b0;
    for (int r = 0; r < 8; r++) any = any | (|m_bank[m_cur][r]);
    e.up  = m_bank[m_cur][r_up];
    e.mid = m_bank[m_cur][bus_if.ra];
    e.dn  = m_bank[m_cur][r_dn];
    e.rdy = &m_mask;
    e.ack = m_ack;
    e.stb = m_stable;
    e.emp = !any;
    e.gen = m_gen;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    cmp("rd_up",    {8'h00, bus_if.rd_up}, {8'h00, e.up});
    cmp("rd",       {8'h00, bus_if.rd},    {8'h00, e.mid});
    cmp("rd_dn",    {8'h00, bus_if.rd_dn}, {8'h00, e.dn});
    cmp("ready",    {15'd0, bus_if.ready},    {15'd0, e.rdy});
    cmp("swap_ack", {15'd0, bus_if.swap_ack}, {15'd0, e.ack});
    cmp("stable",   {15'd0, bus_if.stable},   {15'd0, e.stb});
    cmp("empty",    {15'd0, bus_if.empty},    {15'd0, e.emp});
    cmp("gen",      {14'd0, bus_if.gen},      {14'd0, e.gen});
  endtask

  task automatic tick();
    @(posedge ph2);
    model_edge();
    push_exp();
    #2;
    check_pop();
  endtask

  task automatic look(input logic [R-1:0] a);
    bus_if.ra = a;
    #1;
    push_exp();
    check_pop();
  endtask

  task automatic idle();
    bus_if.load = 1'b0; bus_if.regwrite = 1'b0; bus_if.swap_req = 1'b0;
  endtask

  task automatic wr(input logic [R-1:0] a, input logic [W-1:0] d);
    bus_if.regwrite = 1'b1; bus_if.wa = a; bus_if.wd = d;
    tick();
    bus_if.regwrite = 1'b0;
  endtask

  task automatic do_swap();
    bus_if.swap_req = 1'b1;
    tick();
    bus_if.swap_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [W-1:0] d;
    vectors = 0; miscompares = 0;
    ph2 = 1'b0; reset = 1'b1;
    bus_if.ra = 3'd0; bus_if.wa = 3'd0; bus_if.wd = 8'h00;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Host load of rows 0..7, then wrap-around reads.
    for (int i = 0; i < 8; i++) begin
      bus_if.load = 1'b1; bus_if.wa = 3'(i); bus_if.wd = 8'(i + 1);
      tick();
    end
    idle();
    look(3'd0);
    look(3'd7);
    look(3'd4);

    // Swap request held while rows are still missing.
    bus_if.swap_req = 1'b1;
    for (int i = 0; i < 7; i++) wr(3'(i), 8'h10 + 8'(i));
    wr(3'd7, 8'h17);
    tick();
    bus_if.swap_req = 1'b0;
    tick();
    look(3'd0);

    // Identical next generation, then one with row 3 changed.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    do_swap();
    for (int i = 0; i < 8; i++) wr(3'(i), (i == 3) ? 8'h55 : 8'h10 + 8'(i));
    do_swap();

    // Load and regwrite together: load wins, mask bit stays clear.
    bus_if.load = 1'b1; bus_if.regwrite = 1'b1; bus_if.wa = 3'd2; bus_if.wd = 8'hAA;
    tick();
    idle();
    look(3'd2);
    foreach (m_mask[i]) if (i != 2) wr(3'(i), 8'h20 + 8'(i));
    tick();

    // Reset mid-generation with everything else asserted.
    idle();
    for (int i = 0; i < 5; i++) wr(3'(i), 8'h30 + 8'(i));
    reset = 1'b1;
    bus_if.load = 1'b1; bus_if.regwrite = 1'b1; bus_if.swap_req = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    tick();
    for (int i = 0; i < 8; i++) look(3'(i));

    // Five generations to exercise counter wrap; the last board is all zero.
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 8; i++) begin
        d = (g == 4) ? 8'h00 : 8'($urandom_range(1, 255));
        wr(3'(i), d);
      end
      if (g == 2) begin
        // Swap coincident with a rewrite of row 0.
        bus_if.swap_req = 1'b1; bus_if.regwrite = 1'b1; bus_if.wa = 3'd0; bus_if.wd = 8'h5A;
        tick();
        idle();
        tick();
      end else begin
        do_swap();
      end
      look(3'd1);
    end

    // Host loads an all-zero board, then a swap is taken.
    for (int i = 0; i < 8; i++) begin
      bus_if.load = 1'b1; bus_if.wa = 3'(i); bus_if.wd = 8'h00;
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h00);
    do_swap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
